// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
// Bundles the channel request side and the registered output side of
// rr_mux_arbiter.
//   mode      0 = round-robin grant, 1 = fixed select
//   sel       channel index used in fixed mode
//   in_data   NCH packed words, channel i at [i*SIZE +: SIZE]
//   in_valid  per-channel request
//   in_ready  per-channel accept (driven by the arbiter)
//   out_data  registered output word
//   out_sel   channel that supplied out_data
//   out_valid out_data holds an undelivered word
//   out_ready downstream accept
// slave modport: arbiter view. master modport: the side driving requests
// and consuming the output.
interface rr_mux_arbiter_if #(
  parameter int SIZE = 32,
  parameter int NCH  = 4,
  parameter int SELW = 2
);
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [NCH*SIZE-1:0] in_data;
  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [SIZE-1:0]     out_data;
  logic [SELW-1:0]     out_sel;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// N-channel registered multiplexer with valid/ready handshakes. One
// requesting channel is granted per transfer, round-robin or by a fixed
// select, and its word is held in a one-entry output register.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arbiter_if.slave (requests in, registered word out)
module rr_mux_arbiter #(
  parameter int SIZE = 32,
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_if.slave    bus
);

  logic [SIZE-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q,  out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q,      ptr_d;

  logic [NCH-1:0]  grant_vec;
  logic [SELW-1:0] grant_idx;
  logic            grant_any;
  logic [SELW:0]   cand;
  logic            load_en;
  logic            take;

  // Grant search. Round-robin walks ptr, ptr+1, ... modulo NCH and keeps
  // the first valid channel; cand carries one extra bit so the wrap
  // compare against NCH cannot overflow.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (!bus.mode) begin
      for (int k = 0; k < NCH; k++) begin
        cand = {1'b0, ptr_q} + (SELW+1)'(k);
        if (cand >= (SELW+1)'(NCH)) cand = cand - (SELW+1)'(NCH);
        if (!grant_any && bus.in_valid[cand[SELW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[SELW-1:0];
        end
      end
    end else if (({1'b0, bus.sel} < (SELW+1)'(NCH)) && bus.in_valid[bus.sel]) begin
      grant_any = 1'b1;
      grant_idx = bus.sel;
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  assign load_en = ~out_valid_q | bus.out_ready;
  assign take    = grant_any & load_en;

  // rst_n gates in_ready directly so no channel sees an accept while the
  // output register is being cleared.
  assign bus.in_ready = (rst_n && load_en) ? grant_vec : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (take) begin
      out_data_d  = bus.in_data[grant_idx*SIZE +: SIZE];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (!bus.mode) begin
        if (grant_idx == SELW'(NCH-1)) ptr_d = '0;
        else                           ptr_d = grant_idx + 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      // Drained with nothing to replace it; data/sel keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
  localparam int SIZE = 32;
  localparam int NCH  = 4;
  localparam int SELW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.SIZE(SIZE), .NCH(NCH), .SELW(SELW)) bus ();

  rr_mux_arbiter #(.SIZE(SIZE), .NCH(NCH), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference state
  bit        m_valid;
  int        m_sel;
  logic [31:0] m_data;
  int        m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_grant(input bit m, input int s, input logic [3:0] v, input int ptr);
    if (m) return (s < NCH && v[s]) ? s : -1;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (ptr + k) % NCH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_data = 0; m_ptr = 0;
  endtask

  // One cycle: drive inputs, check combinational accept and held state,
  // clock, then advance the reference.
  task automatic step(input bit m, input logic [1:0] s, input logic [3:0] v,
                      input bit ordy, input logic [127:0] d);
    int g;
    bit load;
    logic [3:0] exp_rdy;
    @(negedge clk);
    bus.mode = m; bus.sel = s; bus.in_valid = v; bus.out_ready = ordy; bus.in_data = d;
    #1;
    g = ref_grant(m, int'(s), v, m_ptr);
    load = !m_valid || ordy;
    exp_rdy = (rst_n && load && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("out_sel", 64'(bus.out_sel), 64'(m_sel));
    chk("out_data", 64'(bus.out_data), 64'(m_data));
    @(posedge clk);
    if (rst_n) begin
      if (g >= 0 && load) begin
        m_data = d[g*32 +: 32];
        m_sel = g;
        m_valid = 1;
        if (!m) m_ptr = (g + 1) % NCH;
      end else if (m_valid && ordy) begin
        m_valid = 0;
      end
    end
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] AX = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  initial begin
    logic [31:0] held;
    logic [127:0] d;
    logic [1:0] s;
    logic [31:0] zlo, zhi, z;
    int e0;

    bus.mode = 0; bus.sel = 0; bus.in_valid = 0; bus.out_ready = 0; bus.in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // some traffic, then a mid-stream reset
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), rnd_data());
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_sel", 64'(bus.out_sel), 64'd0);
    step(0, 0, 4'b1111, 1, AX);
    step(0, 0, 4'b1111, 0, AX);
    #2 rst_n = 1'b1;

    // round-robin fairness from ptr=0
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'b1111, 1, AX);
      #1;
      chk("rr_sel", 64'(bus.out_sel), 64'(i % 4));
      chk("rr_data", 64'(bus.out_data), 64'(32'hA0 + (i % 4)));
    end

    // pointer skip (ptr is 1 here)
    d = AX; d[2*32 +: 32] = 32'hDEADBEEF;
    step(0, 0, 4'b0100, 1, d);
    #1 chk("skip_sel2", 64'(bus.out_sel), 64'd2);
    chk("skip_data", 64'(bus.out_data), 64'hDEADBEEF);
    step(0, 0, 4'b1010, 1, AX);
    #1 chk("skip_sel3", 64'(bus.out_sel), 64'd3);
    step(0, 0, 4'b1010, 1, AX);
    #1 chk("skip_sel1", 64'(bus.out_sel), 64'd1);

    // back-pressure: word from ch1 held, ptr=2
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b1111, 0, AX);
      #1 chk("bp_hold", 64'(bus.out_data), 64'(held));
      chk("bp_rdy", 64'(bus.in_ready), 64'd0);
    end
    step(0, 0, 4'b1111, 1, AX);
    #1 chk("bp_next", 64'(bus.out_sel), 64'd2);

    // fixed select
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b10, 4'b1111, 1, rnd_data());
      #1 chk("fix_sel", 64'(bus.out_sel), 64'd2);
    end
    step(1, 2'b10, 4'b1011, 1, AX);
    #1 chk("fix_drop", 64'(bus.out_valid), 64'd0);

    // fixed-mode regression against the 4:1 mux expression
    for (int i = 0; i < 10; i++) begin
      d = rnd_data();
      s = 2'($urandom);
      zlo = s[0] ? d[63:32]  : d[31:0];
      zhi = s[0] ? d[127:96] : d[95:64];
      z   = s[1] ? zhi : zlo;
      e0 = errors;
      step(1, s, 4'b1111, 1, d);
      #1 chk("mux_vec", 64'(bus.out_data), 64'(z));
      if (errors == e0) $display("vec %0d PASS", i);
    end

    // broad random traffic against the reference
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) == 0), 2'($urandom), 4'($urandom),
           1'($urandom_range(0, 3) != 0), rnd_data());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
